mac_accumulator: RTL

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

---
 rtl/mac_accumulator.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mac_accumulator.sv
// Pipelined 32x32 unsigned multiply-accumulate over in_last-delimited blocks; result 2 edges after the last accept.
// A result held with out_ready=0 stalls the whole pipe and drops in_ready; ACC_W legal range is 64..128.

module mac_mul32 (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [63:0] p_o,
    output logic        cout_o
);
    assign p_o    = 64'(a_i) * 64'(b_i);
    assign cout_o = |p_o[63:32];
endmodule

module mac_accumulator #(
    parameter int ACC_W = 80
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [15:0]      out_count,
    output logic             out_ovf
);
    logic             s1_vld_q;
    logic [31:0]      s1_a_q;
    logic [31:0]      s1_b_q;
    logic             s1_last_q;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [15:0]      cnt_q;
    logic [15:0]      cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             first_q;
    logic             out_vld_q;
    logic [ACC_W-1:0] out_dat_q;
    logic [15:0]      out_cnt_q;
    logic             out_ovf_q;

    logic [63:0]      prod;
    logic             mul_cout_unused;
    logic [ACC_W-1:0] base;
    logic [ACC_W:0]   sum;
    logic             advance;
    logic             xfer;
    logic             load_res;

    mac_mul32 u_mul (
        .a_i    (s1_a_q),
        .b_i    (s1_b_q),
        .p_o    (prod),
        .cout_o (mul_cout_unused)
    );

    assign advance  = !(out_vld_q && !out_ready);
    assign xfer     = in_valid && advance;
    assign load_res = advance && s1_vld_q && s1_last_q;

    always_comb begin
        base  = first_q ? '0 : acc_q;
        sum   = {1'b0, base} + {1'b0, ACC_W'(prod)};
        acc_d = sum[ACC_W-1:0];
        // A new block restarts the sticky overflow from this term's carry alone.
        ovf_d = (!first_q && ovf_q) || sum[ACC_W];
        if (first_q)
            cnt_d = 16'd1;
        else if (cnt_q == 16'hFFFF)
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_a_q    <= '0;
            s1_b_q    <= '0;
            s1_last_q <= 1'b0;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            first_q   <= 1'b1;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            out_cnt_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            if (advance) begin
                s1_vld_q <= xfer;
                if (xfer) begin
                    s1_a_q    <= a;
                    s1_b_q    <= b;
                    s1_last_q <= in_last;
                end
                if (s1_vld_q) begin
                    acc_q   <= acc_d;
                    cnt_q   <= cnt_d;
                    ovf_q   <= ovf_d;
                    first_q <= s1_last_q;
                end
            end
            if (load_res) begin
                out_vld_q <= 1'b1;
                out_dat_q <= acc_d;
                out_cnt_q <= cnt_d;
                out_ovf_q <= ovf_d;
            end else if (out_vld_q && out_ready) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign in_ready  = advance;
    assign out_valid = out_vld_q;
    assign out_data  = out_dat_q;
    assign out_count = out_cnt_q;
    assign out_ovf   = out_ovf_q;
endmodule
